regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port register file and the next-generation integer register file for the RISC-V core.
- Configurable width, depth and number of read/write ports.
- Registered (1-cycle) reads with write-first forwarding.
- Optional hardwired zero register and per-port read hold for pipeline stalls.
- Sits between decode (read addresses) and writeback (write ports). Reset clears the whole array.

Parameters:
DATA_W, 32, register width in bits
DEPTH, 32, number of registers (need not be a power of 2)
ADDR_W, $clog2(DEPTH), address width (derived, not overridden)
NUM_RD, 2, number of read ports
NUM_WR, 1, number of write ports
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is ordinary

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears array and read outputs
reg_write  in  NUM_WR  write enable per write port
w_addr  in  NUM_WR*ADDR_W  write address, port j at bits [j*ADDR_W +: ADDR_W]
w_data  in  NUM_WR*DATA_W  write data, port j at [j*DATA_W +: DATA_W]
r_en  in  NUM_RD  read enable per read port; 0 = hold output (stall)
r_addr  in  NUM_RD*ADDR_W  read address, port i packed as for w_addr
r_data  out  NUM_RD*DATA_W  registered read data, port i packed as for w_data

Behaviour:
- Reset: asserting reset immediately (no clock needed) sets all DEPTH registers to 0 and all r_data to 0. While reset is high, writes and reads are ignored. Deassertion is synchronised externally.
- Write: on posedge, for each port j with reg_write[j]=1 and valid address, reg[w_addr[j]] <= w_data[j].
- An address is invalid if it is >= DEPTH, or if it is 0 and ZERO_REG=1. Invalid writes are dropped silently.
- Same-address multi-write in one cycle: the highest-index port wins. Lower ports to that address have no effect.
- Read latency is exactly 1 cycle. On posedge with r_en[i]=1, r_data[i] <= the value reg[r_addr[i]] will hold after this edge's writes (write-first):
  - If any enabled write port targets r_addr[i] with a valid address, forward that w_data, using highest-index priority.
  - Otherwise return the stored value.
- Invalid read address returns 0, including address 0 when ZERO_REG=1, even if a write targets it.
- r_en[i]=0: r_data[i] holds its previous value. Writes proceed regardless of r_en.
- Read ports are fully independent. Any number may read the same address in one cycle.
- Reset mid-operation: a write on the same edge as reset assertion is lost. r_data reads 0 on the first edge after release unless a read is enabled.
- No combinational path from any input to r_data.

Decomposition:
- Package regfile_pkg:
  - default localparams DATA_W_DEF=32, DEPTH_DEF=32, NUM_RD_DEF=2, NUM_WR_DEF=1
  - helper function addr_valid(addr, depth, zero_reg)
- Sub-module regfile_fwd, instantiated once per read port. Combinational and parametrised by NUM_WR. Given r_addr, all write ports and the stored value, it returns next-read data with priority forwarding and zero/invalid masking.
- Storage array, write decode and r_data registers live in regfile_mp.

Test Plan:
- Reset with prior contents: write 0xDEADBEEF to x5, assert reset mid-cycle -> r_data and reg x5 read 0 immediately; after release, read x5 -> 0x00000000 one cycle later.
- Basic write/read: write 0x12345678 to x7, next cycle read x7 on both ports -> both r_data = 0x12345678 exactly 1 cycle after the address is presented.
- Forwarding: same cycle, write 0xA5A5A5A5 to x3 and read x3 (old value 0x11) -> r_data = 0xA5A5A5A5 after the edge. With ZERO_REG=1, same test on x0 -> 0.
- Multi-write conflict (NUM_WR=2): port0 writes 0x1 and port1 writes 0x2 to x9 in one cycle -> forwarded and stored value are 0x2.
- Stall hold: read x4 (=0x44) with r_en=1, then r_en=0 while writing 0x99 to x4 -> r_data stays 0x44. Re-enable -> 0x99.
- Non-power-of-2 (DEPTH=24): write 0xFF to address 30 -> dropped; read address 30 -> 0; registers 0..23 unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and address-validity helper for the multi-port integer register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 32;
  localparam int NUM_RD_DEF = 2;
  localparam int NUM_WR_DEF = 1;

  // Out-of-range entries and a hardwired x0 are both treated as "no such register".
  function automatic logic addr_valid(input int unsigned addr, input int unsigned depth,
                                      input logic zero_reg);
    return (addr < depth) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/regfile_fwd.sv
// Next-read value for one read port: write-first forwarding with highest-port priority,
// then masking of invalid addresses to zero.
module regfile_fwd
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_W   = 5,
  parameter int NUM_WR   = NUM_WR_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0]        i_rd_addr,
  input  logic [NUM_WR-1:0]        i_wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
  input  logic [DATA_W-1:0]        i_stored,
  output logic [DATA_W-1:0]        o_rd_next
);

  logic w_rd_valid;

  assign w_rd_valid = addr_valid(32'(i_rd_addr), DEPTH, ZERO_REG != 0);

  always_comb begin
    o_rd_next = i_stored;
    // Ascending scan so the highest-index matching port is the one left standing.
    for (int j = 0; j < NUM_WR; j++) begin
      if (i_wr_en[j] &&
          addr_valid(32'(i_wr_addr[j*ADDR_W +: ADDR_W]), DEPTH, ZERO_REG != 0) &&
          (i_wr_addr[j*ADDR_W +: ADDR_W] == i_rd_addr)) begin
        o_rd_next = i_wr_data[j*DATA_W +: DATA_W];
      end
    end
    if (!w_rd_valid) begin
      o_rd_next = '0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NUM_WR write ports, NUM_RD registered read ports
// with write-first forwarding and per-port stall hold.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int NUM_WR   = NUM_WR_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_WR-1:0]        reg_write,
  input  logic [NUM_WR*ADDR_W-1:0] w_addr,
  input  logic [NUM_WR*DATA_W-1:0] w_data,
  input  logic [NUM_RD-1:0]        r_en,
  input  logic [NUM_RD*ADDR_W-1:0] r_addr,
  output logic [NUM_RD*DATA_W-1:0] r_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  w_we;
  logic [DATA_W-1:0] w_wdata [DEPTH];

  // Per-register write decode; a later port overrides an earlier one on the same address.
  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_we[k]    = 1'b0;
      w_wdata[k] = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (reg_write[j] &&
            addr_valid(32'(w_addr[j*ADDR_W +: ADDR_W]), DEPTH, ZERO_REG != 0) &&
            (w_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(k))) begin
          w_we[k]    = 1'b1;
          w_wdata[k] = w_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_we[k]) begin
          r_mem[k] <= w_wdata[k];
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] w_raddr;
    logic [DATA_W-1:0] w_stored;
    logic [DATA_W-1:0] w_next;
    logic [DATA_W-1:0] r_rd;

    assign w_raddr  = r_addr[gi*ADDR_W +: ADDR_W];
    // Guard the array index; addresses past DEPTH are zeroed again in the forwarder.
    assign w_stored = (32'(w_raddr) < DEPTH) ? r_mem[w_raddr] : '0;

    regfile_fwd #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .NUM_WR  (NUM_WR),
      .ZERO_REG(ZERO_REG)
    ) u_fwd (
      .i_rd_addr(w_raddr),
      .i_wr_en  (reg_write),
      .i_wr_addr(w_addr),
      .i_wr_data(w_data),
      .i_stored (w_stored),
      .o_rd_next(w_next)
    );

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_rd <= '0;
      end else if (r_en[gi]) begin
        r_rd <= w_next;
      end
    end

    assign r_data[gi*DATA_W +: DATA_W] = r_rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed plus randomised bench for regfile_mp (DEPTH=24, two write ports, two read ports).
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int DP = 24;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NW-1:0]    reg_write;
  logic [NW*AW-1:0] w_addr;
  logic [NW*DW-1:0] w_data;
  logic [NR-1:0]    r_en;
  logic [NR*AW-1:0] r_addr;
  logic [NR*DW-1:0] r_data;

  regfile_mp #(
    .DATA_W  (DW),
    .DEPTH   (DP),
    .NUM_RD  (NR),
    .NUM_WR  (NW),
    .ZERO_REG(1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .reg_write(reg_write),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .r_en     (r_en),
    .r_addr   (r_addr),
    .r_data   (r_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] m[32];
  logic [31:0] last_exp[NR];
  int          total = 0;
  int          bad   = 0;

  function automatic bit valid(input int a);
    return (a < DP) && (a != 0);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 32; k++) m[k] = '0;
    for (int i = 0; i < NR; i++) last_exp[i] = '0;
  endtask

  task automatic check_q();
    exp_t        e;
    logic [31:0] got;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      got = r_data[e.port*DW +: DW];
      total++;
      assert (got === e.exp) else begin
        bad++;
        $error("FAIL %s port%0d got=%h exp=%h", e.tag, e.port, got, e.exp);
      end
      $display("txn %s port%0d r_data=%h", e.tag, e.port, got);
    end
  endtask

  task automatic check_const(input string tag, input int port, input logic [31:0] exp);
    logic [31:0] got;
    got = r_data[port*DW +: DW];
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s port%0d got=%h exp=%h", tag, port, got, exp);
    end
    $display("chk %s port%0d r_data=%h", tag, port, got);
  endtask

  // One clock: drive at negedge, predict, clock, compare at posedge+1.
  task automatic cycle(input string tag, input logic [1:0] we,
                       input int wa0, input logic [31:0] wd0,
                       input int wa1, input logic [31:0] wd1,
                       input logic [1:0] ren, input int ra0, input int ra1);
    logic [31:0] e;
    int          ra;
    exp_t        it;
    reg_write = we;
    w_addr    = {5'(wa1), 5'(wa0)};
    w_data    = {wd1, wd0};
    r_en      = ren;
    r_addr    = {5'(ra1), 5'(ra0)};
    for (int i = 0; i < NR; i++) begin
      ra = (i == 0) ? ra0 : ra1;
      if (ren[i]) begin
        e = valid(ra) ? m[ra] : 32'h0;
        if (we[0] && valid(wa0) && wa0 == ra) e = wd0;
        if (we[1] && valid(wa1) && wa1 == ra) e = wd1;
        if (!valid(ra)) e = 32'h0;
        last_exp[i] = e;
      end
      it.port = i;
      it.exp  = last_exp[i];
      it.tag  = tag;
      sbq.push_back(it);
    end
    if (we[0] && valid(wa0)) m[wa0] = wd0;
    if (we[1] && valid(wa1)) m[wa1] = wd1;
    @(posedge clk);
    #1;
    check_q();
    @(negedge clk);
    reg_write = '0;
    r_en      = '0;
  endtask

  initial begin
    reset     = 1'b1;
    reg_write = '0;
    w_addr    = '0;
    w_data    = '0;
    r_en      = '0;
    r_addr    = '0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check_const("reset_state", 0, 32'h0);
    check_const("reset_state", 1, 32'h0);
    reset = 1'b0;

    // Reset with prior contents, asserted between edges.
    cycle("wr_x5", 2'b01, 5, 32'hDEADBEEF, 0, 0, 2'b00, 0, 0);
    cycle("rd_x5", 2'b00, 0, 0, 0, 0, 2'b11, 5, 5);
    check_const("rd_x5_const", 0, 32'hDEADBEEF);
    #2 reset = 1'b1;
    #1;
    check_const("rst_async", 0, 32'h0);
    check_const("rst_async", 1, 32'h0);
    model_clear();
    @(negedge clk);
    reg_write = 2'b01;
    w_addr    = {5'd0, 5'd6};
    w_data    = {32'h0, 32'h66};
    r_en      = 2'b11;
    r_addr    = {5'd6, 5'd5};
    @(posedge clk);
    #1;
    check_const("rst_held", 0, 32'h0);
    check_const("rst_held", 1, 32'h0);
    @(negedge clk);
    reset     = 1'b0;
    reg_write = '0;
    r_en      = '0;
    cycle("post_rst_idle", 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    cycle("post_rst_rd", 2'b00, 0, 0, 0, 0, 2'b11, 5, 6);
    check_const("x5_cleared", 0, 32'h0);
    check_const("x6_lost", 1, 32'h0);

    // Basic write then read on both ports.
    cycle("wr_x7", 2'b01, 7, 32'h12345678, 0, 0, 2'b00, 0, 0);
    cycle("rd_x7", 2'b00, 0, 0, 0, 0, 2'b11, 7, 7);
    check_const("x7_p0", 0, 32'h12345678);
    check_const("x7_p1", 1, 32'h12345678);

    // Forwarding, and x0 stays zero even when written the same cycle.
    cycle("wr_x3_old", 2'b01, 3, 32'h11, 0, 0, 2'b00, 0, 0);
    cycle("fwd_x3_x0", 2'b11, 3, 32'hA5A5A5A5, 0, 32'h77, 2'b11, 3, 0);
    check_const("fwd_x3", 0, 32'hA5A5A5A5);
    check_const("fwd_x0", 1, 32'h0);

    // Two ports to the same address: port 1 wins, forwarded and stored.
    cycle("conflict_x9", 2'b11, 9, 32'h1, 9, 32'h2, 2'b11, 9, 9);
    check_const("conflict_fwd", 0, 32'h2);
    cycle("conflict_st", 2'b00, 0, 0, 0, 0, 2'b11, 9, 9);
    check_const("conflict_store", 1, 32'h2);

    // Stall hold on port 0 while the register is rewritten.
    cycle("wr_x4", 2'b01, 4, 32'h44, 0, 0, 2'b00, 0, 0);
    cycle("rd_x4", 2'b00, 0, 0, 0, 0, 2'b01, 4, 0);
    cycle("hold_x4", 2'b01, 4, 32'h99, 0, 0, 2'b00, 4, 4);
    check_const("hold_44", 0, 32'h44);
    cycle("reen_x4", 2'b00, 0, 0, 0, 0, 2'b11, 4, 4);
    check_const("reen_99", 0, 32'h99);

    // Out-of-range addresses: dropped on write, zero on read.
    cycle("oob_wr_rd", 2'b11, 30, 32'hFF, 24, 32'hEE, 2'b11, 30, 24);
    check_const("oob_30", 0, 32'h0);
    check_const("oob_24", 1, 32'h0);
    for (int a = 0; a < DP; a += 2) begin
      cycle($sformatf("sweep_x%0d", a), 2'b00, 0, 0, 0, 0, 2'b11, a, a + 1);
    end

    // Randomised traffic over the full 5-bit address space.
    for (int n = 0; n < 40; n++) begin
      cycle($sformatf("rand%0d", n), 2'($urandom_range(0, 3)),
            int'($urandom_range(0, 31)), $urandom(),
            int'($urandom_range(0, 31)), $urandom(),
            2'($urandom_range(0, 3)),
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
